mandelbrot_calc_mc: RTL and testbench
=====================================

MANDELBROT_CALC_MC -- requirements
Module: mandelbrot_calc_mc

Interface
REQ-001 The block SHALL have parameter FPW, default 27, meaning fixed-point word width (two's complement).
REQ-002 The block SHALL have parameter FP_I, default 4, meaning integer bits; fraction bits FP_F = FPW-1-FP_I.
REQ-003 The block SHALL have parameter IW, default 8, meaning iteration-count width.
REQ-004 The block SHALL have parameter AW, default 11, meaning point address width.
REQ-005 The block SHALL have parameter NCH, default 4, meaning number of parallel iteration units (1..16).
REQ-006 The block SHALL have the following ports, clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset.
- clk_en  in  1  global clock enable.
- iter_lim  in  IW  runtime iteration limit, sampled per point at accept.
- in_vld  in  1  input point valid.
- in_rdy  out  1  input ready.
- x_man  in  FPW  c real part.
- y_man  in  FPW  c imaginary part.
- adr_i  in  AW  point address.
- out_vld  out  1  result valid.
- out_rdy  in  1  result ready.
- niter  out  IW  iteration count.
- adr_o  out  AW  address of the result.
REQ-007 The block SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-008 Each unit SHALL be an FSM with states IDLE -> CALC -> DONE -> IDLE.
REQ-009 Transfer rules: an input transfer occurs on an edge with clk_en & in_vld & in_rdy; an output transfer occurs on an edge with clk_en & out_vld & out_rdy.
REQ-010 in_rdy SHALL equal "any unit IDLE"; an accepted point SHALL load the lowest-index IDLE unit.
REQ-011 On accept, the unit SHALL latch c, adr_i and iter_lim, set z=0 and n=0, and enter CALC.
REQ-012 Each CALC cycle SHALL compute x², y² and xy as full 2*FPW products, rescaled by taking bits [FP_F+FPW-1:FP_F].
REQ-013 Escape test: if x²+y² >= 4.0 (evaluated at FPW+1 bits) or n == limit, the unit SHALL go to DONE with niter = n.
REQ-014 Otherwise the unit SHALL update x = x²-y²+cx, y = 2xy+cy, and increment n.
REQ-015 For a point escaping at count k, out_vld from that unit SHALL be visible k+1 edges after the accept edge.
REQ-016 The valid input domain is |x_man|, |y_man| < 2.0; results outside it are unspecified, but the unit SHALL still finish within limit+1 CALC cycles.
REQ-017 Output arbiter: out_vld = "any unit DONE".
REQ-018 The granted unit SHALL be the first DONE unit searching from rr_ptr+1 cyclically; niter and adr_o SHALL be muxed from the granted unit.
REQ-019 On an output transfer, the granted unit SHALL go to IDLE and rr_ptr SHALL take the granted index.
REQ-020 A unit freed on edge t SHALL be loadable on edge t+1 only; in_rdy SHALL be computed from registered state.
REQ-021 Results SHALL be allowed out of order; adr_o identifies each point.
REQ-022 A DONE unit SHALL hold its niter/adr_o stable while out_rdy=0.
REQ-023 With clk_en=0, all state SHALL hold and no transfers SHALL occur; outputs remain as combinational functions of the held state.
REQ-024 A change of iter_lim SHALL NOT affect points already accepted.

Reset
REQ-025 While rst=1 on an edge, all units SHALL go to IDLE, rr_ptr=NCH-1, and in-flight points SHALL be discarded; this takes priority over clk_en.
REQ-026 During reset, out_vld=0, niter=0 and adr_o=0; in_rdy=0 while rst is high and 1 on the first cycle after reset.

Verification
REQ-027 Scenario: iter_lim=255, point x=1.0, y=-1 LSB, adr=5 -> out_vld after 3 edges, niter=2, adr_o=5.
REQ-028 Scenario: iter_lim=255, point (0,0) -> niter=255, out_vld after 256 edges; repeat with iter_lim=0 -> niter=0 after 1 edge.
REQ-029 Scenario: out_rdy=0, NCH points (0,0) issued back-to-back -> in_rdy=0 after the NCH-th accept; then out_rdy=1 -> results with adr 0..NCH-1 drain in round-robin order, one per cycle.
REQ-030 Scenario: point (0,0) with limit 255 then point (1.5,1.5) -> the second result (niter=1) emerges first; adr_o values distinguish the two.
REQ-031 Scenario: clk_en held 0 for 20 cycles mid-CALC -> final niter and latency (counting enabled edges only) identical to the uninterrupted run.
REQ-032 Scenario: rst pulsed for 1 cycle with 3 units busy -> out_vld=0 and all units IDLE next cycle; no stale results afterwards.

Source files
------------

// File: rtl/mandelbrot_calc_mc.sv
// mandelbrot_calc_mc: multi-unit Mandelbrot escape-time calculator.
// NCH iteration units run in parallel. A new point goes to the lowest-index
// idle unit. Finished results leave through a round-robin output arbiter,
// so results can come out in a different order than the points went in.
// adr_o identifies each point.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clk_en            global enable; all state holds while low
//   iter_lim          iteration limit, captured with each accepted point
//   in_vld/in_rdy     point handshake: x_man, y_man (c), adr_i
//   out_vld/out_rdy   result handshake: niter, adr_o

// mandelbrot_unit: one iteration engine (IDLE -> CALC -> DONE -> IDLE).
// niter is the live iteration counter. It is stable once DONE is reached.
module mandelbrot_unit #(
  parameter int FPW  = 27,
  parameter int FP_I = 4,
  parameter int IW   = 8,
  parameter int AW   = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  input  logic           load,
  input  logic           free,
  input  logic [FPW-1:0] cx_in,
  input  logic [FPW-1:0] cy_in,
  input  logic [AW-1:0]  adr_in,
  input  logic [IW-1:0]  lim_in,
  output logic           idle,
  output logic           done,
  output logic [IW-1:0]  niter,
  output logic [AW-1:0]  adr
);
  localparam int FP_F = FPW - 1 - FP_I;
  localparam logic signed [FPW:0] FOUR = (FPW+1)'(4) << FP_F;

  typedef enum logic [1:0] {IDLE, CALC, DONE} st_t;
  st_t st, st_nxt;

  logic signed [FPW-1:0]   x, y, cx, cy, xx, yy, xy;
  logic signed [2*FPW-1:0] pxx, pyy, pxy;
  logic signed [FPW:0]     mag;
  logic [IW-1:0]           lim;
  logic                    fin;

  // Rescale the products by shifting the whole product and truncating to FPW.
  // This keeps bits [FP_F+FPW-1:FP_F]. Wrap-around outside the valid domain is
  // intended.
  always_comb begin
    pxx = x * x;
    pyy = y * y;
    pxy = x * y;
    xx  = FPW'(pxx >>> FP_F);
    yy  = FPW'(pyy >>> FP_F);
    xy  = FPW'(pxy >>> FP_F);
    mag = {xx[FPW-1], xx} + {yy[FPW-1], yy};
    fin = (mag >= FOUR) || (niter == lim);
  end

  always_ff @(posedge clk)
    if (rst)         st <= IDLE;
    else if (clk_en) st <= st_nxt;

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (load) st_nxt = CALC;
      CALC:    if (fin)  st_nxt = DONE;
      DONE:    if (free) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    idle = (st == IDLE);
    done = (st == DONE);
  end

  always_ff @(posedge clk)
    if (rst) begin
      x <= '0; y <= '0; cx <= '0; cy <= '0;
      niter <= '0; lim <= '0; adr <= '0;
    end else if (clk_en) begin
      if (st == IDLE && load) begin
        cx <= cx_in; cy <= cy_in; adr <= adr_in; lim <= lim_in;
        x <= '0; y <= '0; niter <= '0;
      end else if (st == CALC && !fin) begin
        x     <= xx - yy + cx;
        y     <= xy + xy + cy;
        niter <= niter + 1'b1;
      end
    end
endmodule

module mandelbrot_calc_mc #(
  parameter int FPW  = 27,
  parameter int FP_I = 4,
  parameter int IW   = 8,
  parameter int AW   = 11,
  parameter int NCH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  input  logic [IW-1:0]  iter_lim,
  input  logic           in_vld,
  output logic           in_rdy,
  input  logic [FPW-1:0] x_man,
  input  logic [FPW-1:0] y_man,
  input  logic [AW-1:0]  adr_i,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [IW-1:0]  niter,
  output logic [AW-1:0]  adr_o
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]         u_idle, u_done, u_load, u_free;
  logic [NCH-1:0][IW-1:0] u_niter;
  logic [NCH-1:0][AW-1:0] u_adr;
  logic [PW-1:0]          rr_ptr, sel, gnt;
  logic                   acc, xfer;
  int                     idx;

  // Both handshakes depend only on registered unit state. A unit freed on
  // an edge therefore becomes loadable on the following edge.
  assign in_rdy  = !rst && (|u_idle);
  assign out_vld = !rst && (|u_done);
  assign acc     = clk_en && in_vld && in_rdy;
  assign xfer    = clk_en && out_vld && out_rdy;

  // Lowest-index idle unit. The loop runs downward so the smallest index wins.
  always_comb begin
    sel = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (u_idle[i]) sel = PW'(i);
  end

  // First DONE unit found by searching cyclically from rr_ptr+1. The loop runs
  // over descending distance so the nearest hit is the final assignment.
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int k = NCH; k >= 1; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (u_done[idx]) gnt = PW'(idx);
    end
  end

  always_ff @(posedge clk)
    if (rst)       rr_ptr <= PW'(NCH - 1);
    else if (xfer) rr_ptr <= gnt;

  assign niter = out_vld ? u_niter[gnt] : '0;
  assign adr_o = out_vld ? u_adr[gnt]   : '0;

  for (genvar i = 0; i < NCH; i++) begin : g_unit
    assign u_load[i] = acc  && (sel == PW'(i));
    assign u_free[i] = xfer && (gnt == PW'(i));

    mandelbrot_unit #(.FPW(FPW), .FP_I(FP_I), .IW(IW), .AW(AW)) u_unit (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .load   (u_load[i]),
      .free   (u_free[i]),
      .cx_in  (x_man),
      .cy_in  (y_man),
      .adr_in (adr_i),
      .lim_in (iter_lim),
      .idle   (u_idle[i]),
      .done   (u_done[i]),
      .niter  (u_niter[i]),
      .adr    (u_adr[i])
    );
  end
endmodule

// File: tb/tb_mandelbrot_calc_mc.sv
module tb_mandelbrot_calc_mc;
  localparam int FPW = 27, FP_I = 4, FP_F = FPW - 1 - FP_I;
  localparam int IW = 8, AW = 11, NCH = 4, NPTS = 150;
  localparam longint ONE = longint'(1) << FP_F;

  logic clk = 1'b0, rst, clk_en, in_vld, in_rdy, out_vld, out_rdy;
  logic [IW-1:0]  iter_lim, niter;
  logic [FPW-1:0] x_man, y_man;
  logic [AW-1:0]  adr_i, adr_o;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mandelbrot_calc_mc #(.FPW(FPW), .FP_I(FP_I), .IW(IW), .AW(AW), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .iter_lim(iter_lim),
    .in_vld(in_vld), .in_rdy(in_rdy), .x_man(x_man), .y_man(y_man),
    .adr_i(adr_i), .out_vld(out_vld), .out_rdy(out_rdy),
    .niter(niter), .adr_o(adr_o)
  );

  // Reference model: escape-time iteration in plain integer arithmetic
  function automatic longint wrapw(longint v);
    longint m;
    m = v & ((longint'(1) << FPW) - 1);
    if (m >= (longint'(1) << (FPW - 1))) m = m - (longint'(1) << FPW);
    return m;
  endfunction

  function automatic int ref_iter(longint cx, longint cy, int lim);
    longint x = 0, y = 0, xx, yy, xy;
    for (int n = 0; n <= lim; n++) begin
      xx = wrapw((x * x) >>> FP_F);
      yy = wrapw((y * y) >>> FP_F);
      xy = wrapw((x * y) >>> FP_F);
      if (xx + yy >= (longint'(4) << FP_F) || n == lim) return n;
      x = wrapw(xx - yy + cx);
      y = wrapw(2 * xy + cy);
    end
    return lim;
  endfunction

  task automatic send(input longint cx, input longint cy, input int adr, input int lim, output bit ok);
    @(negedge clk);
    x_man = cx[FPW-1:0]; y_man = cy[FPW-1:0];
    adr_i = adr[AW-1:0]; iter_lim = lim[IW-1:0]; in_vld = 1'b1;
    #1 ok = in_rdy && clk_en;
    @(posedge clk);
    #1 in_vld = 1'b0;
  endtask

  task automatic wait_out(input int bound, output int cnt);
    cnt = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1; cnt++;
      if (out_vld) return;
    end
    cnt = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL rst_out_vld: got %b want 0", out_vld); end
    total++; if (niter !== '0) begin bad++; $display("FAIL rst_niter: got %0d want 0", niter); end
    total++; if (adr_o !== '0) begin bad++; $display("FAIL rst_adr_o: got %0d want 0", adr_o); end
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL rst_in_rdy: got %b want 0", in_rdy); end
    @(negedge clk) rst = 1'b0;
    #1;
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL post_rst_in_rdy: got %b want 1", in_rdy); end
  endtask

  task automatic test_escape;
    bit ok; int c;
    out_rdy = 1'b1;
    send(ONE, -1, 5, 255, ok);
    total++; if (!ok) begin bad++; $display("FAIL esc_accept: got 0 want 1"); end
    wait_out(10, c);
    total++; if (c != 3) begin bad++; $display("FAIL esc_latency: got %0d want 3", c); end
    total++; if (niter !== 8'd2) begin bad++; $display("FAIL esc_niter: got %0d want 2", niter); end
    total++; if (adr_o !== 11'd5) begin bad++; $display("FAIL esc_adr: got %0d want 5", adr_o); end
    @(posedge clk); #1;
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL esc_drain: got %b want 0", out_vld); end
  endtask

  task automatic test_limit;
    bit ok; int c;
    out_rdy = 1'b1;
    send(0, 0, 1, 255, ok);
    wait_out(300, c);
    total++; if (c != 256) begin bad++; $display("FAIL lim255_latency: got %0d want 256", c); end
    total++; if (niter !== 8'd255) begin bad++; $display("FAIL lim255_niter: got %0d want 255", niter); end
    @(posedge clk);
    send(0, 0, 2, 0, ok);
    wait_out(10, c);
    total++; if (c != 1) begin bad++; $display("FAIL lim0_latency: got %0d want 1", c); end
    total++; if (niter !== 8'd0 || adr_o !== 11'd2) begin bad++; $display("FAIL lim0_result: got n=%0d a=%0d want n=0 a=2", niter, adr_o); end
    @(posedge clk);
  endtask

  task automatic test_back_to_back;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    out_rdy = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      @(negedge clk);
      x_man = '0; y_man = '0; adr_i = AW'(i); iter_lim = 8'd10; in_vld = 1'b1;
      #1;
      total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL b2b_rdy%0d: got %b want 1", i, in_rdy); end
    end
    @(posedge clk); #1 in_vld = 1'b0;
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL b2b_full: got %b want 0", in_rdy); end
    repeat (15) @(posedge clk);
    @(negedge clk) out_rdy = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      #1;
      total++;
      if (out_vld !== 1'b1 || adr_o !== AW'(i) || niter !== 8'd10) begin
        bad++; $display("FAIL b2b_drain%0d: got v=%b a=%0d n=%0d want v=1 a=%0d n=10", i, out_vld, adr_o, niter, i);
      end
      @(negedge clk);
    end
    #1;
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL b2b_empty: got %b want 0", out_vld); end
  endtask

  task automatic test_out_of_order;
    bit ok1, ok2; int c;
    out_rdy = 1'b1;
    send(0, 0, 10, 255, ok1);
    send(longint'(3) << (FP_F - 1), longint'(3) << (FP_F - 1), 11, 255, ok2);
    total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL ooo_accept: got %b%b want 11", ok1, ok2); end
    wait_out(10, c);
    total++; if (c != 2 || adr_o !== 11'd11 || niter !== 8'd1) begin
      bad++; $display("FAIL ooo_first: got c=%0d a=%0d n=%0d want c=2 a=11 n=1", c, adr_o, niter); end
    wait_out(300, c);
    total++; if (adr_o !== 11'd10 || niter !== 8'd255) begin
      bad++; $display("FAIL ooo_second: got a=%0d n=%0d want a=10 n=255", adr_o, niter); end
    @(posedge clk);
  endtask

  task automatic test_clk_en;
    bit ok, seen; int c;
    out_rdy = 1'b1;
    send(0, 0, 7, 40, ok);
    repeat (10) @(posedge clk);
    #1 clk_en = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1 if (out_vld) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("FAIL cen_hold_calc: got out_vld=1 want 0"); end
    clk_en = 1'b1;
    wait_out(100, c);
    total++; if (c + 10 != 41) begin bad++; $display("FAIL cen_latency: got %0d want 41", c + 10); end
    total++; if (niter !== 8'd40 || adr_o !== 11'd7) begin bad++; $display("FAIL cen_result: got n=%0d a=%0d want n=40 a=7", niter, adr_o); end
    clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_vld !== 1'b1 || adr_o !== 11'd7) begin bad++; $display("FAIL cen_no_xfer: got v=%b a=%0d want v=1 a=7", out_vld, adr_o); end
    clk_en = 1'b1;
    @(posedge clk); #1;
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL cen_resume_xfer: got %b want 0", out_vld); end
  endtask

  task automatic test_reset_mid;
    bit ok, seen;
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) send(0, 0, 20 + i, 255, ok);
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    total++; if (out_vld !== 1'b0 || in_rdy !== 1'b0) begin bad++; $display("FAIL rmid_during: got v=%b r=%b want 0 0", out_vld, in_rdy); end
    @(negedge clk) rst = 1'b0;
    #1;
    total++; if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin bad++; $display("FAIL rmid_after: got v=%b r=%b want 0 1", out_vld, in_rdy); end
    seen = 1'b0;
    repeat (300) begin @(posedge clk); #1 if (out_vld) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("FAIL rmid_stale: got result want none"); end
  endtask

  task automatic test_random;
    longint pcx = 0, pcy = 0;
    int plim = 0, sent = 0, rcvd = 0;
    bit have = 1'b0;
    int exp_n[2048];
    bit pend[2048];
    for (int i = 0; i < 2048; i++) begin exp_n[i] = 0; pend[i] = 1'b0; end
    for (int cyc = 0; cyc < 20000 && rcvd < NPTS; cyc++) begin
      @(negedge clk);
      if (!have && sent < NPTS) begin
        pcx = longint'($urandom_range(0, 2**24 - 2)) - longint'(2**23 - 1);
        pcy = longint'($urandom_range(0, 2**24 - 2)) - longint'(2**23 - 1);
        plim = int'($urandom_range(0, 48));
        have = 1'b1;
      end
      in_vld = have && ($urandom_range(0, 3) != 0);
      x_man = pcx[FPW-1:0]; y_man = pcy[FPW-1:0]; adr_i = sent[AW-1:0];
      iter_lim = in_vld ? plim[IW-1:0] : IW'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      clk_en = ($urandom_range(0, 9) != 0);
      #1;
      if (clk_en && in_vld && in_rdy) begin
        exp_n[sent] = ref_iter(pcx, pcy, plim); pend[sent] = 1'b1; sent++; have = 1'b0;
      end
      if (clk_en && out_vld && out_rdy) begin
        total++;
        if (!pend[adr_o] || int'(niter) != exp_n[adr_o]) begin
          bad++; $display("FAIL rnd_result a=%0d: got n=%0d pend=%b want n=%0d", adr_o, niter, pend[adr_o], exp_n[adr_o]);
        end
        pend[adr_o] = 1'b0; rcvd++;
      end
    end
    @(negedge clk) begin in_vld = 1'b0; clk_en = 1'b1; end
    total++; if (rcvd != NPTS) begin bad++; $display("FAIL rnd_count: got %0d want %0d", rcvd, NPTS); end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
    iter_lim = '0; x_man = '0; y_man = '0; adr_i = '0;
    test_reset;
    test_escape;
    test_limit;
    test_back_to_back;
    test_out_of_order;
    test_clk_en;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
